dtw_core_scheduler: RTL and testbench
=====================================

# dtw_core_scheduler

Query dispatcher and result merger that shares one incoming query stream among `NUM_CORES` `dtw_core` instances, all of which hold the same reference in normal mode. It picks an idle core round-robin, starts it, and streams one query packet into that core's source FIFO. A second, independent arbiter drains the per-core 3-word result packets into a single output stream.

## Interface
- `NUM_CORES`, 4: number of cores; 2..16.
- `SQG_SIZE`, 256: samples per query; query packet = 1 qid word + `SQG_SIZE` sample words.
- `AXIS_WIDTH`, 32: stream word width.

- `clk`  in  1  clock.
- `rst`  in  1  reset; asynchronous and active-high.
- `enable`  in  1  permits new dispatches; a packet in flight always completes.
- `in_valid` / `in_ready` / `in_data`  in/out/in  1/1/`AXIS_WIDTH`  query stream, valid/ready.
- `core_busy`  in  `NUM_CORES`  per-core busy.
- `core_rs`  out  `NUM_CORES`  one-cycle start pulse per core; op_mode is tied to normal externally.
- `core_wr_en`  out  `NUM_CORES`  write strobe into a core's source FIFO.
- `core_wr_data`  out  `AXIS_WIDTH`  shared write data for all cores.
- `core_fifo_full`  in  `NUM_CORES`  source FIFO full.
- `res_valid`  in  `NUM_CORES`  sink FIFO non-empty; sink FIFOs are first-word-fall-through.
- `res_data`  in  `NUM_CORES*AXIS_WIDTH`  sink FIFO heads; core i occupies bits [i*W +: W].
- `res_rd_en`  out  `NUM_CORES`  sink FIFO pop.
- `out_valid` / `out_ready` / `out_data` / `out_last`  out/in/out/out  1/1/`AXIS_WIDTH`/1  merged result stream.
- `n_dispatched`, `n_completed`  out  32  packet counters; wrap modulo 2^32.

## Operation
- Per-core `assigned` bit: set on the core's start pulse, cleared when the third result word is popped. A core is *free* when `!assigned && !core_busy`.
- Dispatch FSM:
  - IDLE: go to SELECT when `enable`.
  - SELECT: if any core is free, choose the first free index at or after `rr_ptr`, cyclically. Latch it as `sel` and go to START. If `enable` is low, go to IDLE.
  - START: `core_rs[sel]`=1 for exactly one cycle and set `assigned[sel]`. Go to WAIT_BUSY.
  - WAIT_BUSY: stay until `core_busy[sel]`=1. The core clears its source FIFO while idle, so no data is written before busy. Then go to STREAM with `wcnt`=0.
  - STREAM: `in_ready = !core_fifo_full[sel]`. On each handshake, `core_wr_en[sel]`=1, `core_wr_data`=`in_data`, and `wcnt`++. The handshake with `wcnt==SQG_SIZE` is the last word. After it: `n_dispatched`++, `rr_ptr = sel+1` mod `NUM_CORES`, go to SELECT.
- Result FSM (independent of dispatch):
  - R_IDLE: pick the first core with `res_valid` at or after `rr_res`, cyclically. Latch `rsel`, `rcnt`=0, go to R_XFER.
  - R_XFER:
    - `out_valid = res_valid[rsel]`; `out_data = res_data[rsel]`; `out_last = (rcnt==2)`.
    - `res_rd_en[rsel] = out_valid && out_ready`.
    - On the third pop: clear `assigned[rsel]`, `n_completed`++, `rr_res = rsel+1`, return to R_IDLE.
  - A packet is never interleaved with another core's packet.
- Simultaneous events:
  - A clear of `assigned` and a set of `assigned` on the same index cannot occur, because a set requires the bit to be clear.
  - Different indices update independently in the same cycle.
- Only one `core_wr_en` bit is ever high, and only one `res_rd_en` bit is ever high.

## Timing
- Reset (async) state:
  - Both FSMs at IDLE / R_IDLE; `rr_ptr`, `rr_res`, `wcnt`, `rcnt`, `assigned` and counters at 0.
  - All outputs 0: `core_rs`, `core_wr_en`, `core_wr_data`, `in_ready`, `res_rd_en`, `out_valid`, `out_data`, `out_last`.
  - Reset mid-packet discards the partial packet; no recovery of the core is attempted.
- `in_ready`, `core_wr_en`, `core_wr_data`, `out_*` and `res_rd_en` are combinational from state and inputs. This gives zero-latency pass-through.
- Dispatch overhead: SELECT → START → WAIT_BUSY is 3 cycles minimum, plus the core's busy latency (1 cycle). Streaming then runs at 1 word/cycle when not stalled.
- Result throughput: 3 words in 3 cycles, plus 1 R_IDLE cycle per packet.
- `core_fifo_full` and `!in_valid` each stall STREAM with no state change. `out_ready`=0 holds R_XFER.

## Structure
- Package `dtw_sched_pkg`: dispatch and result state enums, `RES_WORDS`=3, and the round-robin first-set-from-pointer function.
- One sub-module, `rr_pick`: a parameterised cyclic priority encoder (request vector and pointer in; index and found flag out). It is instantiated twice.

## Test plan
- `NUM_CORES`=4, `SQG_SIZE`=8, all cores free, 4 back-to-back queries (qid 10..13) → `core_rs` pulses on cores 0,1,2,3 in order. Each core receives exactly 9 words, the first being its qid. `n_dispatched`=4.
- Core 1 held busy, cores 0 and 2 free, `rr_ptr`=1 → dispatch goes to core 2, not core 0.
- `core_fifo_full[sel]` asserted for 5 cycles mid-packet → `in_ready`=0 for those 5 cycles, no words are lost or duplicated, and the packet completes with 9 writes.
- Cores 0 and 3 present results simultaneously (qid 7/pos 100/min 55 and qid 9/pos 4/min 2), `rr_res`=0 → output is 7,100,55 then 9,4,2. `out_last` is set on the 3rd and 6th words, and `n_completed`=2.
- `out_ready` toggled 1,0,1,0 during a result packet → exactly 3 pops, data held stable while `out_ready`=0.
- `rst` asserted mid-STREAM and mid-R_XFER → all outputs 0 immediately (asynchronous). After release, the first dispatch targets core 0.

Source files
------------

// File: rtl/dtw_sched_pkg.sv
// Shared types for the DTW core scheduler: FSM state enums, result packet length
// and the cyclic first-set search used by both round-robin arbiters.
package dtw_sched_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_SELECT,
      S_START,
      S_WAIT_BUSY,
      S_STREAM
   } disp_state_t;

   typedef enum logic {
      R_IDLE,
      R_XFER
   } res_state_t;

   localparam int RES_WORDS = 3;
   localparam int MAX_CORES = 16;

   // Returns {found, index}: the first set bit of req at or after ptr, wrapping at n.
   function automatic logic [4:0] rr_first(input logic [MAX_CORES-1:0] req,
                                           input logic [3:0]           ptr,
                                           input int                   n);
      logic [4:0] res;
      int         k;
      res = '0;
      for (int i = 0; i < MAX_CORES; i++) begin
         k = int'(ptr) + i;
         if (k >= n) k = k - n;
         if ((i < n) && !res[4] && req[k[3:0]]) res = {1'b1, k[3:0]};
      end
      return res;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Cyclic priority encoder: first asserted request at or after the pointer.
module rr_pick #(
   parameter int N  = 4,
   parameter int IW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [IW-1:0] idx,
   output logic          found
);
   import dtw_sched_pkg::*;

   logic [4:0] pick;
   logic       unused_pick;

   always_comb begin
      pick  = rr_first(MAX_CORES'(req), 4'(ptr), N);
      idx   = pick[IW-1:0];
      found = pick[4];
   end

   assign unused_pick = ^pick[3:0];

endmodule

// File: rtl/dtw_core_scheduler.sv
// Dispatches query packets round-robin to idle DTW cores and merges their
// 3-word result packets back into a single output stream.
module dtw_core_scheduler #(
   parameter int NUM_CORES  = 4,
   parameter int SQG_SIZE   = 256,
   parameter int AXIS_WIDTH = 32
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            enable,
   input  logic                            in_valid,
   output logic                            in_ready,
   input  logic [AXIS_WIDTH-1:0]           in_data,
   input  logic [NUM_CORES-1:0]            core_busy,
   output logic [NUM_CORES-1:0]            core_rs,
   output logic [NUM_CORES-1:0]            core_wr_en,
   output logic [AXIS_WIDTH-1:0]           core_wr_data,
   input  logic [NUM_CORES-1:0]            core_fifo_full,
   input  logic [NUM_CORES-1:0]            res_valid,
   input  logic [NUM_CORES*AXIS_WIDTH-1:0] res_data,
   output logic [NUM_CORES-1:0]            res_rd_en,
   output logic                            out_valid,
   input  logic                            out_ready,
   output logic [AXIS_WIDTH-1:0]           out_data,
   output logic                            out_last,
   output logic [31:0]                     n_dispatched,
   output logic [31:0]                     n_completed
);
   import dtw_sched_pkg::*;

   localparam int IW = $clog2(NUM_CORES);
   localparam int CW = $clog2(SQG_SIZE + 1);

   disp_state_t          disp_state_q, disp_state_d;
   logic [IW-1:0]        sel_q, sel_d;
   logic [IW-1:0]        rr_ptr_q, rr_ptr_d;
   logic [CW-1:0]        wcnt_q, wcnt_d;
   logic [31:0]          n_disp_q, n_disp_d;
   res_state_t           res_state_q, res_state_d;
   logic [IW-1:0]        rsel_q, rsel_d;
   logic [IW-1:0]        rr_res_q, rr_res_d;
   logic [1:0]           rcnt_q, rcnt_d;
   logic [31:0]          n_comp_q, n_comp_d;
   logic [NUM_CORES-1:0] assigned_q, assigned_d;
   logic [NUM_CORES-1:0] set_vec, clr_vec;
   logic [NUM_CORES-1:0] free_vec;
   logic [IW-1:0]        disp_idx, res_idx;
   logic                 disp_found, res_found;
   logic                 in_fire, out_fire;

   assign free_vec = ~assigned_q & ~core_busy;

   rr_pick #(.N(NUM_CORES), .IW(IW)) u_disp_pick (
      .req   (free_vec),
      .ptr   (rr_ptr_q),
      .idx   (disp_idx),
      .found (disp_found)
   );

   rr_pick #(.N(NUM_CORES), .IW(IW)) u_res_pick (
      .req   (res_valid),
      .ptr   (rr_res_q),
      .idx   (res_idx),
      .found (res_found)
   );

   always_comb begin
      disp_state_d = disp_state_q;
      sel_d        = sel_q;
      rr_ptr_d     = rr_ptr_q;
      wcnt_d       = wcnt_q;
      n_disp_d     = n_disp_q;
      set_vec      = '0;
      core_rs      = '0;
      core_wr_en   = '0;
      core_wr_data = '0;
      in_ready     = 1'b0;
      in_fire      = 1'b0;
      case (disp_state_q)
         S_IDLE: begin
            if (enable) disp_state_d = S_SELECT;
         end
         S_SELECT: begin
            if (!enable) begin
               disp_state_d = S_IDLE;
            end else if (disp_found) begin
               sel_d        = disp_idx;
               disp_state_d = S_START;
            end
         end
         S_START: begin
            core_rs[sel_q] = 1'b1;
            set_vec[sel_q] = 1'b1;
            disp_state_d   = S_WAIT_BUSY;
         end
         // The core flushes its source FIFO while idle, so writes wait for busy.
         S_WAIT_BUSY: begin
            if (core_busy[sel_q]) begin
               wcnt_d       = '0;
               disp_state_d = S_STREAM;
            end
         end
         S_STREAM: begin
            in_ready = !core_fifo_full[sel_q];
            in_fire  = in_valid && in_ready;
            if (in_fire) begin
               core_wr_en[sel_q] = 1'b1;
               core_wr_data      = in_data;
               if (wcnt_q == CW'(SQG_SIZE)) begin
                  n_disp_d     = n_disp_q + 32'd1;
                  rr_ptr_d     = (sel_q == IW'(NUM_CORES - 1)) ? '0 : sel_q + IW'(1);
                  disp_state_d = S_SELECT;
               end else begin
                  wcnt_d = wcnt_q + CW'(1);
               end
            end
         end
         default: disp_state_d = S_IDLE;
      endcase
   end

   always_comb begin
      res_state_d = res_state_q;
      rsel_d      = rsel_q;
      rr_res_d    = rr_res_q;
      rcnt_d      = rcnt_q;
      n_comp_d    = n_comp_q;
      clr_vec     = '0;
      res_rd_en   = '0;
      out_valid   = 1'b0;
      out_data    = '0;
      out_last    = 1'b0;
      out_fire    = 1'b0;
      case (res_state_q)
         R_IDLE: begin
            if (res_found) begin
               rsel_d      = res_idx;
               rcnt_d      = '0;
               res_state_d = R_XFER;
            end
         end
         R_XFER: begin
            out_valid = res_valid[rsel_q];
            out_data  = res_data[rsel_q*AXIS_WIDTH +: AXIS_WIDTH];
            out_last  = (rcnt_q == 2'(RES_WORDS - 1));
            out_fire  = out_valid && out_ready;
            if (out_fire) begin
               res_rd_en[rsel_q] = 1'b1;
               if (rcnt_q == 2'(RES_WORDS - 1)) begin
                  clr_vec[rsel_q] = 1'b1;
                  n_comp_d        = n_comp_q + 32'd1;
                  rr_res_d        = (rsel_q == IW'(NUM_CORES - 1)) ? '0 : rsel_q + IW'(1);
                  res_state_d     = R_IDLE;
               end else begin
                  rcnt_d = rcnt_q + 2'd1;
               end
            end
         end
         default: res_state_d = R_IDLE;
      endcase
   end

   // Set and clear never collide on one index: a set needs the bit already clear.
   assign assigned_d = (assigned_q | set_vec) & ~clr_vec;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         disp_state_q <= S_IDLE;
         sel_q        <= '0;
         rr_ptr_q     <= '0;
         wcnt_q       <= '0;
         n_disp_q     <= '0;
         res_state_q  <= R_IDLE;
         rsel_q       <= '0;
         rr_res_q     <= '0;
         rcnt_q       <= '0;
         n_comp_q     <= '0;
         assigned_q   <= '0;
      end else begin
         disp_state_q <= disp_state_d;
         sel_q        <= sel_d;
         rr_ptr_q     <= rr_ptr_d;
         wcnt_q       <= wcnt_d;
         n_disp_q     <= n_disp_d;
         res_state_q  <= res_state_d;
         rsel_q       <= rsel_d;
         rr_res_q     <= rr_res_d;
         rcnt_q       <= rcnt_d;
         n_comp_q     <= n_comp_d;
         assigned_q   <= assigned_d;
      end
   end

   assign n_dispatched = n_disp_q;
   assign n_completed  = n_comp_q;

endmodule

// File: tb/tb_dtw_core_scheduler.sv
// Self-checking bench for dtw_core_scheduler: behavioural core models, a query
// scoreboard and a round-robin predictor, driven by directed and random traffic.
module tb_dtw_core_scheduler;

   localparam int NC  = 4;
   localparam int SQG = 8;
   localparam int PKT = SQG + 1;

   logic           clk;
   logic           rst;
   logic           enable;
   logic           in_valid;
   logic           in_ready;
   logic [31:0]    in_data;
   logic [NC-1:0]  core_busy;
   logic [NC-1:0]  core_rs;
   logic [NC-1:0]  core_wr_en;
   logic [31:0]    core_wr_data;
   logic [NC-1:0]  core_fifo_full;
   logic [NC-1:0]  res_valid;
   logic [NC*32-1:0] res_data;
   logic [NC-1:0]  res_rd_en;
   logic           out_valid;
   logic           out_ready;
   logic [31:0]    out_data;
   logic           out_last;
   logic [31:0]    n_dispatched;
   logic [31:0]    n_completed;

   dtw_core_scheduler #(.NUM_CORES(NC), .SQG_SIZE(SQG), .AXIS_WIDTH(32)) dut (
      .clk            (clk),
      .rst            (rst),
      .enable         (enable),
      .in_valid       (in_valid),
      .in_ready       (in_ready),
      .in_data        (in_data),
      .core_busy      (core_busy),
      .core_rs        (core_rs),
      .core_wr_en     (core_wr_en),
      .core_wr_data   (core_wr_data),
      .core_fifo_full (core_fifo_full),
      .res_valid      (res_valid),
      .res_data       (res_data),
      .res_rd_en      (res_rd_en),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_data       (out_data),
      .out_last       (out_last),
      .n_dispatched   (n_dispatched),
      .n_completed    (n_completed)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int passCount = 0;
   int checkCount = 0;

   // Stimulus knobs
   int validPct, fullPct, readyPct, readyMode, delayMin, delayMax, holdCore;
   logic [NC-1:0] fullForce;
   logic readyToggle;

   // Query stream and reference state
   logic [31:0] txQ[$];
   int          dispLog[$];
   logic [31:0] outLog[$];
   logic        outLastLog[$];
   logic [NC-1:0] tbAssigned, prevFree, freeNow;
   int rrPtr, curCore, curWords, resCur, expDisp, completeCount, popTotal;

   // Behavioural core models
   logic [31:0] rxBuf[NC][PKT];
   int          rxCount[NC];
   int          coreState[NC];
   int          computeLeft[NC];
   bit          modelBusy[NC];
   bit          forceBusy[NC];
   bit          rsSeen[NC];
   bit          popSeen[NC];
   logic [31:0] sinkMem[NC][8];
   int          sinkHead[NC];
   int          sinkCount[NC];
   int          popIdx[NC];

   for (genvar g = 0; g < NC; g++) begin : gRes
      assign res_valid[g]          = (sinkCount[g] != 0);
      assign res_data[g*32 +: 32]  = sinkMem[g][sinkHead[g][2:0]];
   end

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checkCount++;
      if (actual === expected) passCount++;
      else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
   endtask

   function automatic int predictCore(input logic [NC-1:0] freeVec, input int ptr);
      for (int k = 0; k < NC; k++) begin
         int c;
         c = (ptr + k) % NC;
         if (freeVec[c]) return c;
      end
      return -1;
   endfunction

   function automatic int lowestSet(input logic [NC-1:0] v);
      for (int k = 0; k < NC; k++) if (v[k]) return k;
      return -1;
   endfunction

   task automatic applyStimulus(input logic [31:0] qid);
      txQ.push_back(qid);
      for (int s = 0; s < SQG; s++) txQ.push_back($urandom_range(1000, 0));
   endtask

   task automatic pushSink(input int c, input logic [31:0] w);
      sinkMem[c][(sinkHead[c] + sinkCount[c]) % 8] = w;
      sinkCount[c]++;
   endtask

   // A finished core reports {qid, sum of samples, minimum sample}.
   task automatic pushResult(input int c);
      logic [31:0] sum, mn;
      sum = 0;
      mn  = 32'hFFFF_FFFF;
      for (int s = 1; s < PKT; s++) begin
         sum = sum + rxBuf[c][s];
         if (rxBuf[c][s] < mn) mn = rxBuf[c][s];
      end
      pushSink(c, rxBuf[c][0]);
      pushSink(c, sum);
      pushSink(c, mn);
   endtask

   task automatic clearModel();
      txQ.delete();
      dispLog.delete();
      outLog.delete();
      outLastLog.delete();
      tbAssigned = '0; prevFree = '0;
      rrPtr = 0; curCore = -1; curWords = 0; resCur = -1;
      expDisp = 0; completeCount = 0; popTotal = 0;
      fullForce = '0; holdCore = -1; readyToggle = 1'b0;
      for (int i = 0; i < NC; i++) begin
         rxCount[i] = 0; coreState[i] = 0; computeLeft[i] = 0;
         modelBusy[i] = 0; forceBusy[i] = 0; rsSeen[i] = 0; popSeen[i] = 0;
         sinkHead[i] = 0; sinkCount[i] = 0; popIdx[i] = 0;
      end
      in_valid = 1'b0; in_data = '0; core_busy = '0;
      core_fifo_full = '0; out_ready = 1'b0;
   endtask

   task automatic doReset();
      @(negedge clk); #2;
      rst = 1'b1;
      enable = 1'b0;
      clearModel();
      repeat (2) @(negedge clk);
      #2 rst = 1'b0;
   endtask

   task automatic waitDisp(input int n, input int budget);
      for (int c = 0; c < budget && expDisp < n; c++) @(negedge clk);
      #1 checkOutput("wait_dispatched", expDisp, n);
   endtask

   task automatic waitComp(input int n, input int budget);
      for (int c = 0; c < budget && completeCount < n; c++) @(negedge clk);
      #1 checkOutput("wait_completed", completeCount, n);
   endtask

   task automatic waitWords(input int n, input int budget);
      for (int c = 0; c < budget && curWords < n; c++) begin
         @(negedge clk); #1;
      end
      checkOutput("wait_words", curWords >= n, 1);
   endtask

   // Core models and input drivers advance just after each rising edge.
   initial begin
      forever begin
         @(posedge clk); #1;
         if (!rst) begin
            for (int i = 0; i < NC; i++) begin
               if (rsSeen[i]) begin
                  rsSeen[i] = 0; modelBusy[i] = 1; coreState[i] = 1;
               end else if (coreState[i] == 1 && rxCount[i] == PKT) begin
                  coreState[i] = 2;
                  computeLeft[i] = $urandom_range(delayMax, delayMin);
               end else if (coreState[i] == 2) begin
                  if (computeLeft[i] > 0) computeLeft[i]--;
                  else begin
                     pushResult(i); modelBusy[i] = 0; coreState[i] = 0;
                  end
               end
               if (popSeen[i]) begin
                  popSeen[i] = 0;
                  sinkHead[i] = (sinkHead[i] + 1) % 8;
                  sinkCount[i]--;
               end
               core_busy[i] = modelBusy[i] | forceBusy[i];
               core_fifo_full[i] = fullForce[i] | ($urandom_range(99) < fullPct);
            end
            in_valid = (txQ.size() > 0) && ($urandom_range(99) < validPct);
            in_data  = (txQ.size() > 0) ? txQ[0] : 32'h0;
            if (readyMode == 1) begin
               readyToggle = !readyToggle;
               out_ready = readyToggle;
            end else begin
               out_ready = ($urandom_range(99) < readyPct);
            end
         end
      end
   end

   // Observe the settled cycle at the falling edge and score it.
   always @(negedge clk) begin
      if (!rst) begin
         freeNow = ~tbAssigned & ~core_busy;
         if (core_rs != '0) begin
            int idx;
            idx = lowestSet(core_rs);
            checkOutput("rs_onehot", $countones(core_rs), 1);
            checkOutput("dispatch_core", idx, predictCore(prevFree, rrPtr));
            dispLog.push_back(idx);
            tbAssigned[idx] = 1'b1;
            rsSeen[idx] = 1;
            rxCount[idx] = 0;
            curCore = idx;
            curWords = 0;
         end
         if (in_valid && in_ready) begin
            checkOutput("wr_en", core_wr_en, (curCore >= 0) ? NC'(1 << curCore) : '0);
            checkOutput("wr_data", core_wr_data, txQ[0]);
            if (curCore >= 0 && rxCount[curCore] < PKT) begin
               rxBuf[curCore][rxCount[curCore]] = core_wr_data;
               rxCount[curCore]++;
            end
            void'(txQ.pop_front());
            curWords++;
            if (curWords == PKT) begin
               expDisp++;
               rrPtr = (curCore + 1) % NC;
            end
         end else if (core_wr_en != '0) begin
            checkOutput("wr_without_handshake", core_wr_en, '0);
         end
         if (holdCore >= 0 && out_valid && !out_ready)
            checkOutput("hold_data", out_data, sinkMem[holdCore][sinkHead[holdCore]]);
         if (res_rd_en != '0) begin
            int r;
            r = lowestSet(res_rd_en);
            checkOutput("rd_onehot", $countones(res_rd_en), 1);
            checkOutput("rd_handshake", {out_valid, out_ready}, 2'b11);
            checkOutput("out_data", out_data, sinkMem[r][sinkHead[r]]);
            checkOutput("out_last", out_last, popIdx[r] == 2);
            if (resCur >= 0) checkOutput("no_interleave", r, resCur);
            outLog.push_back(out_data);
            outLastLog.push_back(out_last);
            popSeen[r] = 1;
            popTotal++;
            popIdx[r]++;
            resCur = r;
            if (popIdx[r] == 3) begin
               popIdx[r] = 0;
               resCur = -1;
               tbAssigned[r] = 1'b0;
               completeCount++;
            end
         end
         prevFree = freeNow;
      end
   end

   initial begin
      rst = 1'b1; enable = 1'b0;
      validPct = 100; fullPct = 0; readyPct = 100; readyMode = 0;
      delayMin = 2; delayMax = 4;
      clearModel();

      // Reset state and four back-to-back queries to four free cores
      doReset();
      @(negedge clk); #1;
      checkOutput("rst_core_rs", core_rs, '0);
      checkOutput("rst_wr_en", core_wr_en, '0);
      checkOutput("rst_wr_data", core_wr_data, '0);
      checkOutput("rst_in_ready", in_ready, 0);
      checkOutput("rst_rd_en", res_rd_en, '0);
      checkOutput("rst_out_valid", out_valid, 0);
      checkOutput("rst_out_data", out_data, '0);
      checkOutput("rst_out_last", out_last, 0);
      checkOutput("rst_n_disp", n_dispatched, 0);
      checkOutput("rst_n_comp", n_completed, 0);
      delayMin = 40; delayMax = 50;
      for (int q = 10; q < 14; q++) applyStimulus(q);
      enable = 1'b1;
      waitDisp(4, 600);
      checkOutput("t1_disp_count", dispLog.size(), 4);
      for (int i = 0; i < NC && i < dispLog.size(); i++) begin
         checkOutput("t1_order", dispLog[i], i);
         checkOutput("t1_words", rxCount[i], PKT);
         checkOutput("t1_qid", rxBuf[i][0], 10 + i);
      end
      checkOutput("t1_n_dispatched", n_dispatched, 4);
      waitComp(4, 3000);
      checkOutput("t1_n_completed", n_completed, 4);

      // Core 1 held busy with rr_ptr at 1: core 2 wins over core 0
      doReset();
      delayMin = 2; delayMax = 3;
      forceBusy[1] = 1;
      applyStimulus(20);
      enable = 1'b1;
      waitDisp(1, 300);
      waitComp(1, 300);
      applyStimulus(21);
      waitDisp(2, 300);
      checkOutput("t2_disp_count", dispLog.size(), 2);
      if (dispLog.size() == 2) begin
         checkOutput("t2_first", dispLog[0], 0);
         checkOutput("t2_skip_busy", dispLog[1], 2);
      end

      // Source FIFO full for five cycles mid-packet
      doReset();
      applyStimulus(30);
      enable = 1'b1;
      waitWords(4, 300);
      fullForce = '1;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk); #1;
         checkOutput("t3_full_stall", in_ready, 0);
      end
      fullForce = '0;
      waitDisp(1, 300);
      checkOutput("t3_words", rxCount[0], PKT);
      checkOutput("t3_n_dispatched", n_dispatched, 1);

      // Simultaneous results on cores 0 and 3
      doReset();
      @(negedge clk); #2;
      pushSink(0, 7); pushSink(0, 100); pushSink(0, 55);
      pushSink(3, 9); pushSink(3, 4);   pushSink(3, 2);
      waitComp(2, 200);
      checkOutput("t4_out_count", outLog.size(), 6);
      if (outLog.size() == 6) begin
         logic [31:0] expWords[6];
         expWords = '{7, 100, 55, 9, 4, 2};
         for (int i = 0; i < 6; i++) begin
            checkOutput("t4_word", outLog[i], expWords[i]);
            checkOutput("t4_last", outLastLog[i], (i == 2) || (i == 5));
         end
      end
      checkOutput("t4_n_completed", n_completed, 2);

      // out_ready toggling during a result packet
      doReset();
      readyMode = 1;
      holdCore = 1;
      @(negedge clk); #2;
      pushSink(1, 32'hA1); pushSink(1, 32'hA2); pushSink(1, 32'hA3);
      waitComp(1, 100);
      repeat (4) @(negedge clk);
      #1;
      checkOutput("t5_pops", popTotal, 3);
      checkOutput("t5_sink_empty", sinkCount[1], 0);
      readyMode = 0;

      // Asynchronous reset mid-STREAM and mid-R_XFER
      doReset();
      readyPct = 0;
      delayMin = 40; delayMax = 50;
      @(negedge clk); #2;
      pushSink(2, 1); pushSink(2, 2); pushSink(2, 3);
      applyStimulus(35);
      enable = 1'b1;
      waitWords(3, 300);
      checkOutput("t6_pre_stream", in_ready, 1);
      checkOutput("t6_pre_xfer", out_valid, 1);
      #1 rst = 1'b1;
      #1;
      checkOutput("t6_in_ready", in_ready, 0);
      checkOutput("t6_wr_en", core_wr_en, '0);
      checkOutput("t6_wr_data", core_wr_data, '0);
      checkOutput("t6_core_rs", core_rs, '0);
      checkOutput("t6_out_valid", out_valid, 0);
      checkOutput("t6_out_data", out_data, '0);
      checkOutput("t6_out_last", out_last, 0);
      checkOutput("t6_rd_en", res_rd_en, '0);
      checkOutput("t6_n_disp", n_dispatched, 0);
      enable = 1'b0;
      clearModel();
      repeat (2) @(negedge clk);
      #2 rst = 1'b0;
      readyPct = 100;
      delayMin = 2; delayMax = 4;
      applyStimulus(40);
      enable = 1'b1;
      waitDisp(1, 300);
      if (dispLog.size() > 0) checkOutput("t6_first_core", dispLog[0], 0);
      else checkOutput("t6_first_core_seen", dispLog.size(), 1);

      // Random traffic against the scoreboard and round-robin predictor
      doReset();
      validPct = 70; fullPct = 10; readyPct = 70;
      delayMin = 0; delayMax = 15;
      for (int q = 0; q < 24; q++) applyStimulus($urandom);
      enable = 1'b1;
      waitComp(24, 40000);
      checkOutput("rand_n_dispatched", n_dispatched, 24);
      checkOutput("rand_n_completed", n_completed, 24);
      checkOutput("rand_tx_drained", txQ.size(), 0);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
